ofdm_load_sequencer: RTL and testbench

Parametrised successor to the fixed 64-sample load-select controller. It counts accepted input samples into OFDM symbols of `SYM_LEN` samples and groups symbols into frames of `SYMS_PER_FRAME`. It drives the buffer load-select code (idle / load / run) that steers the input buffer into the IFFT/FFT stage. It also publishes sample and symbol indices and frame markers. It sits between the sample source and the symbol buffer/IFFT datapath, and adds sample-valid qualification, enable/stall, synchronous restart and frame tracking.

---
 rtl/ofdm_defs.sv | 28 ++
 rtl/ofdm_load_sequencer_wrap_counter.sv | 28 ++
 rtl/ofdm_load_sequencer.sv | 98 +++++++++
 tb/tb_ofdm_load_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_defs.sv
// Shared encodings for the OFDM load sequencer: buffer load-select codes
// and controller states.
package ofdm_defs;

  localparam logic [1:0] LSEL_IDLE = 2'd0;
  localparam logic [1:0] LSEL_LOAD = 2'd1;
  localparam logic [1:0] LSEL_RUN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Load-select code presented to the buffer while in a given state.
  function automatic logic [1:0] lsel_of(input state_t st);
    logic [1:0] code;
    code = LSEL_IDLE;
    case (st)
      ST_LOAD: code = LSEL_LOAD;
      ST_RUN:  code = LSEL_RUN;
      default: code = LSEL_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ofdm_load_sequencer_wrap_counter.sv
// Modulo-MOD up-counter with synchronous clear. The wrap flag is high in
// the cycle whose increment takes the count from MOD-1 back to 0.
module wrap_counter #(
  parameter int MOD = 64,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic at_last;

  // Explicit terminal compare so non-power-of-two moduli wrap correctly.
  assign at_last = (cnt == W'(MOD - 1));
  assign wrap    = inc && at_last;

  // Count register; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (inc)    cnt <= at_last ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/ofdm_load_sequencer.sv
// OFDM load-select sequencer: counts accepted samples into symbols and
// symbols into frames, and steers the symbol buffer (idle / load / run).
//
// state | meaning
// IDLE  | waiting for enable after reset
// FILL  | filling the first symbol after reset/restart, buffer idle
// LOAD  | one-cycle load strobe, a sample here is sample 0 of the next symbol
// RUN   | filling subsequent symbols while the IFFT/FFT runs
module ofdm_load_sequencer
  import ofdm_defs::*;
#(
  parameter int SYM_LEN        = 64,
  parameter int SYMS_PER_FRAME = 8,
  parameter int IDX_W          = $clog2(SYM_LEN),
  parameter int SYM_W          = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             in_valid,
  output logic [1:0]       load_sel,
  output logic             load_pulse,
  output logic [IDX_W-1:0] sample_idx,
  output logic [SYM_W-1:0] sym_idx,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  state_t state, state_nxt;
  logic   accept;
  logic   cnt_inc;
  logic   sample_wrap;
  logic   sym_wrap;

  // LOAD never stalls input, so every non-IDLE state accepts samples.
  assign accept  = enable && in_valid && (state != ST_IDLE);
  assign cnt_inc = accept && !restart;

  wrap_counter #(.MOD(SYM_LEN), .W(IDX_W)) u_sample_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .inc   (cnt_inc),
    .cnt   (sample_idx),
    .wrap  (sample_wrap)
  );

  wrap_counter #(.MOD(SYMS_PER_FRAME), .W(SYM_W)) u_sym_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .inc   (sample_wrap),
    .cnt   (sym_idx),
    .wrap  (sym_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; restart overrides every transition.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = ST_FILL;
    end else begin
      case (state)
        ST_IDLE: if (enable) state_nxt = ST_FILL;
        ST_FILL: if (sample_wrap) state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_RUN;
        ST_RUN:  if (sample_wrap) state_nxt = ST_LOAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the upcoming state and counter events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_sel    <= LSEL_IDLE;
      load_pulse  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      load_sel    <= lsel_of(state_nxt);
      load_pulse  <= (state_nxt == ST_LOAD);
      frame_start <= cnt_inc && (sample_idx == '0) && (sym_idx == '0);
      frame_end   <= sym_wrap;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ofdm_load_sequencer.sv
// Bench for ofdm_load_sequencer (SYM_LEN=64, SYMS_PER_FRAME=4): a cycle
// model feeds an expected-output queue, plus hand-derived checkpoints.
module tb_ofdm_load_sequencer;

  localparam int SL  = 64;
  localparam int SPF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] load_sel;
  logic       load_pulse;
  logic [5:0] sample_idx;
  logic [1:0] sym_idx;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  always #5 clk = ~clk;

  ofdm_load_sequencer #(.SYM_LEN(SL), .SYMS_PER_FRAME(SPF)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .in_valid    (in_valid),
    .load_sel    (load_sel),
    .load_pulse  (load_pulse),
    .sample_idx  (sample_idx),
    .sym_idx     (sym_idx),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy)
  );

  typedef struct packed {
    logic [1:0] lsel;
    logic       pulse;
    logic [5:0] sidx;
    logic [1:0] sym;
    logic       fs;
    logic       fe;
    logic       busy;
  } obs_t;

  typedef struct {
    logic       en;
    logic       rs;
    logic       v;
    logic       alt;
    int         n;
    logic [1:0] lsel;
    int         sidx;
    int         sym;
    logic       fe;
  } seg_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: 0 idle, 1 fill, 2 load, 3 run.
  int   m_st = 0;
  int   m_idx = 0;
  int   m_sym = 0;
  logic m_fs = 1'b0;
  logic m_fe = 1'b0;

  function automatic obs_t dut_obs();
    return {load_sel, load_pulse, sample_idx, sym_idx, frame_start, frame_end, busy};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.lsel  = (m_st == 2) ? 2'd1 : (m_st == 3) ? 2'd2 : 2'd0;
    o.pulse = (m_st == 2);
    o.sidx  = 6'(m_idx);
    o.sym   = 2'(m_sym);
    o.fs    = m_fs;
    o.fe    = m_fe;
    o.busy  = (m_st != 0);
    return o;
  endfunction

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_sym = 0; m_fs = 1'b0; m_fe = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic rs, input logic v);
    m_fs = 1'b0;
    m_fe = 1'b0;
    if (rs) begin
      m_st = 1; m_idx = 0; m_sym = 0;
    end else begin
      case (m_st)
        0: if (en) m_st = 1;
        1, 3: if (en && v) begin
          if (m_idx == 0 && m_sym == 0) m_fs = 1'b1;
          if (m_idx == SL - 1) begin
            m_idx = 0;
            m_fe  = (m_sym == SPF - 1);
            m_sym = (m_sym + 1) % SPF;
            m_st  = 2;
          end else begin
            m_idx = m_idx + 1;
          end
        end
        default: begin
          if (en && v) begin
            if (m_idx == 0 && m_sym == 0) m_fs = 1'b1;
            m_idx = m_idx + 1;
          end
          m_st = 3;
        end
      endcase
    end
  endtask

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got lsel=%0d pulse=%0b sidx=%0d sym=%0d fs=%0b fe=%0b busy=%0b, expected lsel=%0d pulse=%0b sidx=%0d sym=%0d fs=%0b fe=%0b busy=%0b",
               name, $time, got.lsel, got.pulse, got.sidx, got.sym, got.fs, got.fe, got.busy,
               exp.lsel, exp.pulse, exp.sidx, exp.sym, exp.fs, exp.fe, exp.busy);
    end
  endtask

  task automatic step(input logic en, input logic rs, input logic v);
    obs_t e;
    enable = en; restart = rs; in_valid = v;
    model_step(en, rs, v);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare("cycle", dut_obs(), e);
  endtask

  seg_t segs[13];

  initial begin
    obs_t zero;
    int   cnt;
    zero = '0;

    //          en    rs    v     alt   n    lsel   sidx sym fe
    segs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   2'd0, 0,   0,  1'b0};
    segs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 64,  2'd1, 0,   1,  1'b0};
    segs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   2'd2, 1,   1,  1'b0};
    segs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 63,  2'd1, 0,   2,  1'b0};
    segs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   2'd2, 0,   2,  1'b0};
    segs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 128, 2'd1, 0,   3,  1'b0};
    segs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   2'd2, 0,   3,  1'b0};
    segs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 64,  2'd1, 0,   0,  1'b1};
    segs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 30,  2'd2, 30,  0,  1'b0};
    segs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10,  2'd2, 30,  0,  1'b0};
    segs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,   2'd0, 0,   0,  1'b0};
    segs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 64,  2'd1, 0,   1,  1'b0};
    segs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   2'd2, 1,   1,  1'b0};

    #1;
    compare("reset_state", dut_obs(), zero);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int s = 0; s < 13; s++) begin
      obs_t cp_got, cp_exp;
      for (int i = 0; i < segs[s].n; i++)
        step(segs[s].en, segs[s].rs, segs[s].alt ? logic'(i % 2) : segs[s].v);
      cp_got = dut_obs();
      cp_exp = cp_got;
      cp_exp.lsel = segs[s].lsel;
      cp_exp.sidx = 6'(segs[s].sidx);
      cp_exp.sym  = 2'(segs[s].sym);
      cp_exp.fe   = segs[s].fe;
      vectors++;
      if (cp_got.lsel !== cp_exp.lsel || cp_got.sidx !== cp_exp.sidx ||
          cp_got.sym !== cp_exp.sym || cp_got.fe !== cp_exp.fe) begin
        miscompares++;
        $display("FAIL checkpoint_%0d: got lsel=%0d sidx=%0d sym=%0d fe=%0b, expected lsel=%0d sidx=%0d sym=%0d fe=%0b",
                 s, cp_got.lsel, cp_got.sidx, cp_got.sym, cp_got.fe,
                 cp_exp.lsel, cp_exp.sidx, cp_exp.sym, cp_exp.fe);
      end
    end

    // Drive into the next LOAD cycle, then hit it with asynchronous reset.
    for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 1'b1);
    vectors++;
    if (load_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_load: got load_pulse=%0b, expected 1", load_pulse);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare("async_reset_in_load", dut_obs(), zero);
    @(posedge clk);
    #1;
    compare("reset_held", dut_obs(), zero);
    reset = 1'b0;

    // One IDLE->FILL cycle plus 64 fresh samples before the first load.
    cnt = 0;
    while (cnt < 200) begin
      step(1'b1, 1'b0, 1'b1);
      cnt++;
      if (load_pulse === 1'b1) break;
    end
    vectors++;
    if (cnt != 65) begin
      miscompares++;
      $display("FAIL first_load_after_reset: got %0d cycles, expected 65", cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
